// File: rtl/note_sequencer_pkg.sv
// musicseq_pkg: shared types and song tables for the note sequencer.
//   note_t   - one melody entry {div (half-period in clk cycles), dur (ticks)}
//   state_t  - sequencer FSM states
//   SONG_*   - constant melody tables, selected by the SONG_SEL parameter
package musicseq_pkg;

  localparam int SEQ_LEN = 8;

  typedef struct packed {
    logic [15:0] div;
    logic [7:0]  dur;
  } note_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // C-major scale, one octave.
  localparam note_t SONG_SCALE [SEQ_LEN] = '{
    '{16'd19084, 8'd4}, '{16'd17007, 8'd4}, '{16'd15169, 8'd4}, '{16'd14317, 8'd4},
    '{16'd12755, 8'd4}, '{16'd11364, 8'd4}, '{16'd10124, 8'd4}, '{16'd9556,  8'd8}
  };

  // Short table exercising rests (div 0), div 1 and dur 0.
  localparam note_t SONG_TEST [SEQ_LEN] = '{
    '{16'd2, 8'd1}, '{16'd3, 8'd2}, '{16'd0, 8'd1}, '{16'd4, 8'd1},
    '{16'd1, 8'd0}, '{16'd2, 8'd1}, '{16'd3, 8'd1}, '{16'd4, 8'd3}
  };

  function automatic note_t song_entry(input int sel, input logic [2:0] idx);
    return (sel == 0) ? SONG_SCALE[idx] : SONG_TEST[idx];
  endfunction

  function automatic logic [15:0] song_div(input int sel, input logic [2:0] idx);
    return (sel == 0) ? SONG_SCALE[idx].div : SONG_TEST[idx].div;
  endfunction

  // Index of the last tick of a note; dur 0 plays as a single tick.
  function automatic logic [7:0] dur_last(input note_t n);
    return (n.dur == 8'd0) ? 8'd0 : n.dur - 8'd1;
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: control and status bundle of the note sequencer.
//   start_i/stop_i/loop_i - playback control (master -> slave)
//   tone_o/lfo_o          - note and tremolo square waves (slave -> master)
//   busy_o/done_o         - playback status
//   note_idx_o            - index of the note being played
interface note_sequencer_if;
  logic       start_i;
  logic       stop_i;
  logic       loop_i;
  logic       tone_o;
  logic       lfo_o;
  logic       busy_o;
  logic       done_o;
  logic [2:0] note_idx_o;

  modport master (
    output start_i, stop_i, loop_i,
    input  tone_o, lfo_o, busy_o, done_o, note_idx_o
  );

  modport slave (
    input  start_i, stop_i, loop_i,
    output tone_o, lfo_o, busy_o, done_o, note_idx_o
  );
endinterface

// File: rtl/note_sequencer_tone_divider.sv
// tone_divider: square-wave generator with a half-period of div clk cycles.
//   clk, rst_n - clock, async active-low reset
//   load       - restart: counter <= div-1, sq <= 0
//   div        - half-period in cycles; 0 holds sq low (rest)
//   sq         - square-wave output, period 2*div
module tone_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] div,
  output logic         sq
);

  logic [W-1:0] cnt;
  logic [W-1:0] reload;

  assign reload = (div == '0) ? '0 : div - W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sq  <= 1'b0;
    end else if (load) begin
      cnt <= reload;
      sq  <= 1'b0;
    end else if (div == '0) begin
      cnt <= '0;
      sq  <= 1'b0;
    end else if (cnt == '0) begin
      cnt <= reload;
      sq  <= ~sq;
    end else begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: steps through a fixed 8-entry melody, producing the note
// square wave (tone_o) and a slow tremolo square wave (lfo_o).
//   clk, rst_n - clock, async active-low reset
//   bus        - note_sequencer_if.slave: start/stop/loop in, waves and status out
//
//   state | meaning
//   IDLE  | waiting for start_i; outputs low
//   PLAY  | playing note note_idx; busy_o high
//   DONE  | one-cycle done_o pulse after the last note without loop
module note_sequencer
  import musicseq_pkg::*;
#(
  parameter int TICK_DIV = 250000,
  parameter int LFO_DIV  = 625000,
  parameter int SONG_SEL = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  note_sequencer_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = $clog2(LFO_DIV + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LFO_HALF = LW'(LFO_DIV);
  localparam logic [2:0]    IDX_LAST = 3'(SEQ_LEN - 1);

  state_t        state, state_nxt;
  logic [2:0]    note_idx, idx_nxt;
  logic [PW-1:0] pre;
  logic [7:0]    tick;
  logic          busy_q, done_q;
  note_t         cur_note;
  logic          note_end, stay_play;
  logic          tone_load, lfo_load;
  logic [15:0]   tone_div;
  logic          tone_sq, lfo_sq;

  always_comb begin
    cur_note  = song_entry(SONG_SEL, note_idx);
    note_end  = (state == ST_PLAY) && (pre == PRE_LAST) && (tick == dur_last(cur_note));

    state_nxt = state;
    case (state)
      ST_IDLE: if (!bus.stop_i && bus.start_i) state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (bus.stop_i)                                       state_nxt = ST_IDLE;
        else if (note_end && note_idx == IDX_LAST && !bus.loop_i) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    stay_play = (state == ST_PLAY) && (state_nxt == ST_PLAY);

    idx_nxt = 3'd0;
    if (stay_play) begin
      if (!note_end)                 idx_nxt = note_idx;
      else if (note_idx != IDX_LAST) idx_nxt = note_idx + 3'd1;
    end

    // The tone divider restarts at every note entry and whenever PLAY is not
    // held, so it must see the div of the note about to start.
    tone_load = !stay_play || note_end;
    tone_div  = tone_load ? song_div(SONG_SEL, idx_nxt) : cur_note.div;
    // The LFO only restarts on entering/leaving PLAY, keeping phase across
    // note boundaries and loops.
    lfo_load  = !stay_play;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      note_idx <= 3'd0;
      pre      <= '0;
      tick     <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      note_idx <= idx_nxt;
      busy_q   <= (state_nxt == ST_PLAY);
      done_q   <= (state_nxt == ST_DONE);
      if (stay_play && !note_end) begin
        if (pre == PRE_LAST) begin
          pre  <= '0;
          tick <= tick + 8'd1;
        end else begin
          pre <= pre + PW'(1);
        end
      end else begin
        pre  <= '0;
        tick <= 8'd0;
      end
    end
  end

  tone_divider #(.W(16)) u_tone (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tone_load),
    .div   (tone_div),
    .sq    (tone_sq)
  );

  tone_divider #(.W(LW)) u_lfo (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfo_load),
    .div   (LFO_HALF),
    .sq    (lfo_sq)
  );

  assign bus.tone_o     = tone_sq;
  assign bus.lfo_o      = lfo_sq;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.note_idx_o = note_idx;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: self-checking bench for note_sequencer (SONG_SEL=1,
// TICK_DIV=10, LFO_DIV=4) against a cycle-level behavioural model that tracks
// time within the note and time since playback start.
module tb_note_sequencer;

  localparam int TD = 10;
  localparam int LD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  note_sequencer_if bus();

  note_sequencer #(.TICK_DIV(TD), .LFO_DIV(LD), .SONG_SEL(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int m_div [8] = '{2, 3, 0, 4, 1, 2, 3, 4};
  int m_dur [8] = '{1, 2, 1, 1, 0, 1, 1, 3};

  bit m_play, m_done;
  int m_idx, m_t, m_p;
  logic e_tone, e_lfo, e_busy, e_done;
  logic [2:0] e_idx;

  function automatic int note_len(input int k);
    return ((m_dur[k] == 0) ? 1 : m_dur[k]) * TD;
  endfunction

  task automatic model_outputs();
    e_busy = m_play;
    e_done = m_done;
    e_idx  = m_play ? 3'(m_idx) : 3'd0;
    e_tone = m_play && (m_div[m_idx] != 0) && (((m_t / m_div[m_idx]) % 2) == 1);
    e_lfo  = m_play && (((m_p / LD) % 2) == 1);
  endtask

  task automatic model_reset();
    m_play = 0; m_done = 0; m_idx = 0; m_t = 0; m_p = 0;
    model_outputs();
  endtask

  task automatic model_edge();
    if (m_play) begin
      if (bus.stop_i) begin
        m_play = 0; m_idx = 0; m_t = 0; m_p = 0;
      end else if (m_t + 1 == note_len(m_idx)) begin
        m_t = 0;
        m_p++;
        if (m_idx == 7) begin
          if (bus.loop_i) m_idx = 0;
          else begin
            m_play = 0; m_done = 1; m_idx = 0; m_p = 0;
          end
        end else begin
          m_idx++;
        end
      end else begin
        m_t++;
        m_p++;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (!bus.stop_i && bus.start_i) begin
      m_play = 1; m_idx = 0; m_t = 0; m_p = 0;
    end
    model_outputs();
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_in(input logic s, input logic p, input logic l);
    bus.start_i = s;
    bus.stop_i  = p;
    bus.loop_i  = l;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o});
    end
    rst_n = 1'b1;
    repeat (3) cycle();
    checks++;
    if ({bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o} !== 7'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 0000000",
               {bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o});
    end
  endtask

  task automatic test_single_play();
    int done_at = -1;
    int done_cnt = 0;
    set_in(1, 0, 0);
    cycle();
    set_in(0, 0, 0);
    checks++;
    if (bus.busy_o !== 1'b1 || bus.tone_o !== 1'b0 || bus.note_idx_o !== 3'd0) begin
      errors++;
      $display("FAIL start_entry: busy=%b tone=%b idx=%0d want busy=1 tone=0 idx=0",
               bus.busy_o, bus.tone_o, bus.note_idx_o);
    end
    for (int n = 1; n <= 116; n++) begin
      cycle();
      checks++;
      if ({bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o} !==
          {e_tone, e_lfo, e_busy, e_done, e_idx}) begin
        errors++;
        $display("FAIL single_play edge %0d: got tlbd_idx=%b want %b", n,
                 {bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o},
                 {e_tone, e_lfo, e_busy, e_done, e_idx});
      end
      if (n == 10) begin
        checks++;
        if (bus.note_idx_o !== 3'd1) begin
          errors++;
          $display("FAIL note1_at_edge10: got %0d want 1", bus.note_idx_o);
        end
      end
      if (bus.done_o === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
    end
    checks++;
    if (done_at != 110 || done_cnt != 1) begin
      errors++;
      $display("FAIL done_pulse: at edge %0d count %0d want edge 110 count 1", done_at, done_cnt);
    end
    checks++;
    if (bus.busy_o !== 1'b0 || bus.lfo_o !== 1'b0) begin
      errors++;
      $display("FAIL after_done: busy=%b lfo=%b want 0 0", bus.busy_o, bus.lfo_o);
    end
  endtask

  task automatic test_loop();
    int done_cnt = 0;
    int wraps = 0;
    logic [2:0] prev_idx = 3'd0;
    set_in(1, 0, 1);
    cycle();
    set_in(0, 0, 1);
    for (int n = 1; n <= 240; n++) begin
      cycle();
      checks++;
      if ({bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o} !==
          {e_tone, e_lfo, e_busy, e_done, e_idx}) begin
        errors++;
        $display("FAIL loop edge %0d: got %b want %b", n,
                 {bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o},
                 {e_tone, e_lfo, e_busy, e_done, e_idx});
      end
      if (bus.done_o === 1'b1) done_cnt++;
      if (prev_idx == 3'd7 && bus.note_idx_o == 3'd0) wraps++;
      prev_idx = bus.note_idx_o;
    end
    checks++;
    if (done_cnt != 0 || wraps != 2) begin
      errors++;
      $display("FAIL loop_wrap: done pulses %0d wraps %0d want 0 and 2", done_cnt, wraps);
    end
    set_in(0, 1, 1);
    cycle();
    set_in(0, 0, 0);
    checks++;
    if ({bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o} !== 7'b0) begin
      errors++;
      $display("FAIL loop_stop: got %b want 0000000",
               {bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o});
    end
  endtask

  task automatic test_stop();
    set_in(1, 0, 0);
    cycle();
    set_in(0, 0, 0);
    repeat (44) cycle();
    checks++;
    if (bus.note_idx_o !== 3'd3 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_stop: idx=%0d busy=%b want 3 1", bus.note_idx_o, bus.busy_o);
    end
    set_in(0, 1, 0);
    cycle();
    checks++;
    if ({bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o} !== 7'b0) begin
      errors++;
      $display("FAIL stop_mid_note: got %b want 0000000",
               {bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o});
    end
    set_in(1, 1, 0);
    for (int n = 0; n < 5; n++) begin
      cycle();
      checks++;
      if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
        errors++;
        $display("FAIL stop_start_idle: busy=%b done=%b want 0 0", bus.busy_o, bus.done_o);
      end
    end
    set_in(0, 0, 0);
    cycle();
  endtask

  task automatic test_start_while_busy();
    set_in(1, 0, 0);
    for (int n = 0; n < 70; n++) begin
      cycle();
      checks++;
      if ({bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o} !==
          {e_tone, e_lfo, e_busy, e_done, e_idx}) begin
        errors++;
        $display("FAIL start_busy edge %0d: got %b want %b", n,
                 {bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o},
                 {e_tone, e_lfo, e_busy, e_done, e_idx});
      end
    end
    set_in(0, 1, 0);
    cycle();
    set_in(0, 0, 0);
    cycle();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom_range(0, 7) == 0), ($urandom_range(0, 79) == 0),
             ($urandom_range(0, 1) == 1));
      cycle();
      checks++;
      if ({bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o} !==
          {e_tone, e_lfo, e_busy, e_done, e_idx}) begin
        errors++;
        bad++;
        if (bad <= 20)
          $display("FAIL random edge %0d: got %b want %b", n,
                   {bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o},
                   {e_tone, e_lfo, e_busy, e_done, e_idx});
      end
    end
    set_in(0, 1, 0);
    cycle();
    set_in(0, 0, 0);
    cycle();
  endtask

  task automatic test_async_reset();
    set_in(1, 0, 0);
    cycle();
    set_in(0, 0, 0);
    repeat (37) cycle();
    checks++;
    if (bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_async_reset: busy=%b want 1", bus.busy_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset: got %b want 0000000",
               {bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      cycle();
      checks++;
      if ({bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o} !==
          {e_tone, e_lfo, e_busy, e_done, e_idx}) begin
        errors++;
        $display("FAIL post_reset edge %0d: got %b want %b", n,
                 {bus.tone_o, bus.lfo_o, bus.busy_o, bus.done_o, bus.note_idx_o},
                 {e_tone, e_lfo, e_busy, e_done, e_idx});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_play();
    test_loop();
    test_stop();
    test_start_while_busy();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
